onehot_seq_decoder: RTL and testbench

- Parametrised binary-to-one-hot decoder with a registered index and a registered one-hot output.
- Generalises the fixed 3-to-8 decoder to any SEL_W-bit select.
- Adds load, up/down stepping with wrap-around, a one-shot scan with done flag, and output enable.
- Drives row/strobe select lines and walking-one scans in the lab designs.

---
 rtl/onehot_seq_decoder_if.sv | 27 ++
 rtl/onehot_seq_decoder.sv | 81 ++++++++
 tb/tb_onehot_seq_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/onehot_seq_decoder_if.sv
// Control and status bundle for onehot_seq_decoder.
// The master drives index/step controls; the slave (decoder) returns the one-hot and status lines.
interface onehot_seq_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             load_i;
  logic [SEL_W-1:0] sel_i;
  logic [1:0]       mode_i;
  logic             step_i;
  logic             en_i;
  logic [OUT_W-1:0] o;
  logic [SEL_W-1:0] idx_o;
  logic             wrap_o;
  logic             done_o;

  modport master (
    output load_i, sel_i, mode_i, step_i, en_i,
    input  o, idx_o, wrap_o, done_o
  );

  modport slave (
    input  load_i, sel_i, mode_i, step_i, en_i,
    output o, idx_o, wrap_o, done_o
  );
endinterface

// File: rtl/onehot_seq_decoder.sv
// Registered binary-to-one-hot decoder with load, wrap-around up/down stepping,
// a one-shot upward scan with a sticky done flag, and an output enable.
module onehot_seq_decoder #(
  parameter int SEL_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  onehot_seq_decoder_if.slave  bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] IDX_TOP = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_HOLD       = 2'b00,
    MODE_UP_WRAP    = 2'b01,
    MODE_DOWN_WRAP  = 2'b10,
    MODE_UP_ONESHOT = 2'b11
  } mode_e;

  mode_e            mode;
  logic [SEL_W-1:0] idx_q, idx_n;
  logic [OUT_W-1:0] o_q;
  logic             wrap_q, wrap_n;
  logic             done_q, done_n;

  assign mode = mode_e'(bus.mode_i);

  // Next-index resolution: load beats any step; done survives only in one-shot mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx_n  = idx_q;
    wrap_n = 1'b0;
    done_n = done_q;
    if (bus.load_i) begin
      idx_n  = bus.sel_i;
      done_n = 1'b0;
    end else begin
      if (mode != MODE_UP_ONESHOT) done_n = 1'b0;
      if (bus.step_i) begin
        case (mode)
          MODE_UP_WRAP: begin
            idx_n  = idx_q + SEL_W'(1);
            wrap_n = (idx_q == IDX_TOP);
          end
          MODE_DOWN_WRAP: begin
            idx_n  = idx_q - SEL_W'(1);
            wrap_n = (idx_q == '0);
          end
          MODE_UP_ONESHOT: begin
            if (!done_q) begin
              if (idx_q == IDX_TOP) done_n = 1'b1;
              else                  idx_n  = idx_q + SEL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: asynchronous reset clears every state bit immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      o_q    <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      idx_q  <= idx_n;
      o_q    <= bus.en_i ? (OUT_W'(1) << idx_n) : '0;
      wrap_q <= wrap_n;
      done_q <= done_n;
    end
  end

  assign bus.o      = o_q;
  assign bus.idx_o  = idx_q;
  assign bus.wrap_o = wrap_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Scoreboard bench for onehot_seq_decoder (SEL_W=3): stimulus pushes hand-computed
// expectations, a monitor pops and compares on each falling edge or on an explicit sample event.
module tb_onehot_seq_decoder;
  localparam int SEL_W = 3;

  typedef struct {
    logic [7:0] o;
    logic [2:0] idx;
    logic       wrap;
    logic       done;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  event sample_ev;

  onehot_seq_decoder_if #(.SEL_W(SEL_W)) bus ();

  onehot_seq_decoder #(.SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got o=%b idx=%0d wrap=%b done=%b, want o=%b idx=%0d wrap=%b done=%b",
               name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest outstanding expectation.
  always begin
    @(negedge clk or sample_ev);
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, {bus.o, bus.idx_o, bus.wrap_o, bus.done_o}, {e.o, e.idx, e.wrap, e.done});
    end
  end

  task automatic push(input string name, input logic [7:0] o, input logic [2:0] idx,
                      input logic wrap, input logic done);
    exp_t e;
    e.o = o; e.idx = idx; e.wrap = wrap; e.done = done; e.name = name;
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; the expectation is checked at the following falling edge.
  task automatic cyc(input string name, input logic load, input logic [2:0] sel,
                     input logic [1:0] mode, input logic step, input logic en,
                     input logic [7:0] exp_o, input logic [2:0] exp_idx,
                     input logic exp_wrap, input logic exp_done);
    @(negedge clk);
    #1;
    bus.load_i = load;
    bus.sel_i  = sel;
    bus.mode_i = mode;
    bus.step_i = step;
    bus.en_i   = en;
    push(name, exp_o, exp_idx, exp_wrap, exp_done);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n      = 1'b0;
    bus.load_i = 1'b0;
    bus.sel_i  = '0;
    bus.mode_i = 2'b00;
    bus.step_i = 1'b0;
    bus.en_i   = 1'b0;

    #2;
    push("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Load and wrap-around stepping
    cyc("load5",      1, 3'd5, 2'b00, 0, 1, 8'b0010_0000, 3'd5, 0, 0);
    cyc("load6",      1, 3'd6, 2'b00, 0, 1, 8'b0100_0000, 3'd6, 0, 0);
    cyc("up_6to7",    0, 3'd0, 2'b01, 1, 1, 8'b1000_0000, 3'd7, 0, 0);
    cyc("up_wrap",    0, 3'd0, 2'b01, 1, 1, 8'b0000_0001, 3'd0, 1, 0);
    cyc("wrap_pulse", 0, 3'd0, 2'b01, 0, 1, 8'b0000_0001, 3'd0, 0, 0);
    cyc("down_wrap",  0, 3'd0, 2'b10, 1, 1, 8'b1000_0000, 3'd7, 1, 0);
    cyc("down_7to6",  0, 3'd0, 2'b10, 1, 1, 8'b0100_0000, 3'd6, 0, 0);

    // One-shot scan from 0: seven climbing steps, then top-reaching and ignored steps
    cyc("os_load0",   1, 3'd0, 2'b11, 0, 1, 8'b0000_0001, 3'd0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      logic [2:0] ii;
      ii = 3'(i);
      cyc($sformatf("os_step%0d", i), 0, 3'd0, 2'b11, 1, 1, 8'(1) << ii, ii, 0, 0);
    end
    cyc("os_step8",   0, 3'd0, 2'b11, 1, 1, 8'b1000_0000, 3'd7, 0, 1);
    cyc("os_step9",   0, 3'd0, 2'b11, 1, 1, 8'b1000_0000, 3'd7, 0, 1);
    cyc("os_hold",    0, 3'd0, 2'b11, 0, 1, 8'b1000_0000, 3'd7, 0, 1);
    cyc("os_load2",   1, 3'd2, 2'b11, 0, 1, 8'b0000_0100, 3'd2, 0, 0);
    cyc("os_load7",   1, 3'd7, 2'b11, 0, 1, 8'b1000_0000, 3'd7, 0, 0);
    cyc("os_top",     0, 3'd0, 2'b11, 1, 1, 8'b1000_0000, 3'd7, 0, 1);
    cyc("done_clr",   0, 3'd0, 2'b00, 0, 1, 8'b1000_0000, 3'd7, 0, 0);

    // Output enable gates only o
    cyc("en0_load1",  1, 3'd1, 2'b01, 0, 0, 8'b0000_0000, 3'd1, 0, 0);
    cyc("en0_step1",  0, 3'd0, 2'b01, 1, 0, 8'b0000_0000, 3'd2, 0, 0);
    cyc("en0_step2",  0, 3'd0, 2'b01, 1, 0, 8'b0000_0000, 3'd3, 0, 0);
    cyc("en0_step3",  0, 3'd0, 2'b01, 1, 0, 8'b0000_0000, 3'd4, 0, 0);
    cyc("en_reraise", 0, 3'd0, 2'b01, 0, 1, 8'b0001_0000, 3'd4, 0, 0);

    // Load beats step at the wrap point
    cyc("load7",      1, 3'd7, 2'b01, 0, 1, 8'b1000_0000, 3'd7, 0, 0);
    cyc("load_vs_st", 1, 3'd3, 2'b01, 1, 1, 8'b0000_1000, 3'd3, 0, 0);
    cyc("pre_reset",  0, 3'd0, 2'b11, 1, 1, 8'b0001_0000, 3'd4, 0, 0);

    // Asynchronous reset in the middle of a cycle, then held across an edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    -> sample_ev;
    bus.load_i = 1'b1;
    bus.sel_i  = 3'd5;
    bus.en_i   = 1'b1;
    push("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc("post_reset", 1, 3'd2, 2'b00, 0, 1, 8'b0000_0100, 3'd2, 0, 0);
    cyc("idle",       0, 3'd0, 2'b00, 0, 1, 8'b0000_0100, 3'd2, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
